// File: rtl/fifo_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rr_arbiter_pkg
// Shared definitions for the round-robin FIFO drain controller:
//   - state_t   : FSM state encodings (IDLE, READ, LATCH, SEND)
//   - DEF_NUM_SRC: default number of upstream FIFOs
//   - src_w_of  : source-index width for a given source count
//   - cnt_w_of  : burst-counter width for a given BURST limit
// -----------------------------------------------------------------------------
package fifo_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_LATCH = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    localparam int DEF_NUM_SRC = 2;

    // Width of a source index (SRC_W = $clog2(NUM_SRC)); never below 1 bit.
    function automatic int src_w_of(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    // The burst counter only has to hold 0..BURST-1.
    function automatic int cnt_w_of(input int burst);
        return (burst > 1) ? $clog2(burst) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// fifo_rr_arbiter_rr_pick
// Combinational next-grant selector with per-source burst fairness.
//   src_empty  in  NUM_SRC  per-source empty flags
//   last_grant in  SRC_W    grant used for the previous word
//   burst_cnt  in  CNT_W    consecutive repeats already given to last_grant
//   next_grant out SRC_W    source to read next (valid when any_req)
//   any_req    out 1        at least one source is non-empty
// -----------------------------------------------------------------------------
module fifo_rr_arbiter_rr_pick
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int BURST   = 4,
    parameter int SRC_W   = src_w_of(NUM_SRC),
    parameter int CNT_W   = cnt_w_of(BURST)
) (
    input  logic [NUM_SRC-1:0] src_empty,
    input  logic [SRC_W-1:0]   last_grant,
    input  logic [CNT_W-1:0]   burst_cnt,
    output logic [SRC_W-1:0]   next_grant,
    output logic               any_req
);

    logic found;
    int   idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        any_req    = ~&src_empty;
        next_grant = last_grant;
        found      = 1'b0;
        idx        = 0;

        if (!src_empty[last_grant] && (int'(burst_cnt) < BURST - 1)) begin
            found = 1'b1;
        end else begin
            // Scan last+1, last+2, ... and finally last itself, so a lone
            // requester keeps the grant even with a saturated burst count.
            for (int k = 1; k <= NUM_SRC; k++) begin
                idx = (int'(last_grant) + k) % NUM_SRC;
                if (!found && !src_empty[idx]) begin
                    next_grant = SRC_W'(idx);
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rr_arbiter
// Round-robin drain controller sharing one ready/valid consumer between
// NUM_SRC upstream FIFOs with one-cycle registered read latency.
//   clk        in  1              system clock
//   rst        in  1              asynchronous active-high reset
//   src_empty  in  NUM_SRC        per-source FIFO empty flags
//   src_dout   in  NUM_SRC*WIDTH  flattened FIFO read data, slice i = source i
//   src_rd_en  out NUM_SRC        one-hot-or-zero FIFO read strobe
//   out_valid  out 1              out_data/out_src hold a word
//   out_ready  in  1              consumer accepts when out_valid && out_ready
//   out_data   out WIDTH          word being offered
//   out_src    out SRC_W          source index of out_data
//   busy       out 1              FSM is not in IDLE
// One word every 4 cycles at best: IDLE -> READ -> LATCH -> SEND.
// -----------------------------------------------------------------------------
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int BURST   = 4,
    parameter int SRC_W   = src_w_of(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       src_empty,
    input  logic [NUM_SRC*WIDTH-1:0] src_dout,
    output logic [NUM_SRC-1:0]       src_rd_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]         out_src,
    output logic                     busy
);

    localparam int CNT_W = cnt_w_of(BURST);

    state_t             state_q,      state_d;
    logic [SRC_W-1:0]   grant_q,      grant_d;
    logic [SRC_W-1:0]   prev_grant_q, prev_grant_d;
    logic               prev_valid_q, prev_valid_d;
    logic [CNT_W-1:0]   burst_cnt_q,  burst_cnt_d;
    logic [NUM_SRC-1:0] rd_en_q,      rd_en_d;
    logic               out_valid_q,  out_valid_d;
    logic [WIDTH-1:0]   out_data_q,   out_data_d;
    logic [SRC_W-1:0]   out_src_q,    out_src_d;

    logic [SRC_W-1:0]   pick_grant;
    logic               any_req;

    fifo_rr_arbiter_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .BURST   (BURST),
        .SRC_W   (SRC_W),
        .CNT_W   (CNT_W)
    ) u_pick (
        .src_empty  (src_empty),
        .last_grant (grant_q),
        .burst_cnt  (burst_cnt_q),
        .next_grant (pick_grant),
        .any_req    (any_req)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        prev_grant_d = prev_grant_q;
        prev_valid_d = prev_valid_q;
        burst_cnt_d  = burst_cnt_q;
        rd_en_d      = '0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d             = pick_grant;
                    rd_en_d[pick_grant] = 1'b1;
                    state_d             = ST_READ;
                end
            end
            ST_READ: begin
                // The FIFO presents the word during the next cycle.
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                out_data_d  = src_dout[int'(grant_q)*WIDTH +: WIDTH];
                out_src_d   = grant_q;
                out_valid_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    // The first word after reset starts a fresh burst.
                    if (prev_valid_q && (grant_q == prev_grant_q)) begin
                        if (int'(burst_cnt_q) < BURST - 1) begin
                            burst_cnt_d = burst_cnt_q + 1'b1;
                        end
                    end else begin
                        burst_cnt_d = '0;
                    end
                    prev_grant_d = grant_q;
                    prev_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the output data register is reset too, so a reset
            // mid-transfer visibly clears the offered word.
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            prev_grant_q <= '0;
            prev_valid_q <= 1'b0;
            burst_cnt_q  <= '0;
            rd_en_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of the others.
            state_q      <= state_d;
            grant_q      <= grant_d;
            prev_grant_q <= prev_grant_d;
            prev_valid_q <= prev_valid_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_en_q      <= rd_en_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
        end
    end

    assign src_rd_en = rd_en_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
module tb_fifo_rr_arbiter;

    typedef struct packed {
        logic [0:0] src;
        logic [7:0] data;
    } word_t;

    int    tests = 0;
    int    fails = 0;
    word_t exp_q[$];
    int    hs_cyc[$];
    int    cyc = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: 2 sources, BURST=4
    logic [1:0]  empty_a, rd_en_a;
    logic [15:0] dout_flat_a;
    logic        valid_a, busy_a;
    logic        ready_a = 1'b0;
    logic [7:0]  data_a;
    logic [0:0]  src_a;

    fifo_rr_arbiter #(.WIDTH(8), .NUM_SRC(2), .BURST(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .src_empty (empty_a),
        .src_dout  (dout_flat_a),
        .src_rd_en (rd_en_a),
        .out_valid (valid_a),
        .out_ready (ready_a),
        .out_data  (data_a),
        .out_src   (src_a),
        .busy      (busy_a)
    );

    // DUT B: 3 sources, for the wrap-around scan
    logic [2:0]  empty_b, rd_en_b;
    logic [23:0] dout_flat_b;
    logic        valid_b, busy_b;
    logic        ready_b = 1'b1;
    logic [7:0]  data_b;
    logic [1:0]  src_b;

    fifo_rr_arbiter #(.WIDTH(8), .NUM_SRC(3), .BURST(4)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .src_empty (empty_b),
        .src_dout  (dout_flat_b),
        .src_rd_en (rd_en_b),
        .out_valid (valid_b),
        .out_ready (ready_b),
        .out_data  (data_b),
        .out_src   (src_b),
        .busy      (busy_b)
    );

    // FIFO models: registered read, dout forced to 0 when not reading.
    logic [7:0] mem_a [2][64];
    int         wp_a [2] = '{0, 0};
    int         rp_a [2] = '{0, 0};
    logic [7:0] fd_a [2] = '{8'h00, 8'h00};
    logic [7:0] mem_b [3][64];
    int         wp_b [3] = '{0, 0, 0};
    int         rp_b [3] = '{0, 0, 0};
    logic [7:0] fd_b [3] = '{8'h00, 8'h00, 8'h00};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en_a[i] && rp_a[i] != wp_a[i]) begin
                fd_a[i] <= mem_a[i][rp_a[i]];
                rp_a[i] <= rp_a[i] + 1;
            end else begin
                fd_a[i] <= 8'h00;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (rd_en_b[i] && rp_b[i] != wp_b[i]) begin
                fd_b[i] <= mem_b[i][rp_b[i]];
                rp_b[i] <= rp_b[i] + 1;
            end else begin
                fd_b[i] <= 8'h00;
            end
        end
    end

    assign dout_flat_a = {fd_a[1], fd_a[0]};
    assign dout_flat_b = {fd_b[2], fd_b[1], fd_b[0]};
    for (genvar g = 0; g < 2; g++) begin : g_ea
        assign empty_a[g] = (rp_a[g] == wp_a[g]);
    end
    for (genvar g = 0; g < 3; g++) begin : g_eb
        assign empty_b[g] = (rp_b[g] == wp_b[g]);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int s, input logic [7:0] v, input bit expect_it);
        mem_a[s][wp_a[s]] = v;
        wp_a[s]++;
        if (expect_it) exp_q.push_back(word_t'{src: 1'(s), data: v});
    endtask

    task automatic push_b(input int s, input logic [7:0] v);
        mem_b[s][wp_b[s]] = v;
        wp_b[s]++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic drain_a(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || busy_a) && t < 500) begin
            step();
            t++;
        end
        check(tag, 32'((exp_q.size() == 0) && !busy_a), 32'd1);
    endtask

    task automatic wait_valid_a(input string tag);
        int t = 0;
        while (!valid_a && t < 50) begin
            step();
            t++;
        end
        check(tag, 32'(valid_a), 32'd1);
    endtask

    // what: 0 = rd_en_b pulse, 1 = valid_b, 2 = back to idle
    task automatic wait_b(input int what, input string tag);
        int  t = 0;
        bit  hit;
        hit = 1'b0;
        while (!hit && t < 50) begin
            case (what)
                0: hit = (rd_en_b != 3'b000);
                1: hit = valid_b;
                default: hit = !busy_b;
            endcase
            if (!hit) begin
                step();
                t++;
            end
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    // Scoreboard monitor and read-strobe sanity, sampled on the falling edge.
    always @(negedge clk) begin
        word_t w;
        cyc++;
        if (!rst && valid_a && ready_a) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected: observed word 0x%0h src %0d expected none", data_a, src_a);
            end
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("sb_data", 32'(data_a), 32'(w.data));
                check("sb_src", 32'(src_a), 32'(w.src));
                hs_cyc.push_back(cyc);
            end
        end
        if (rd_en_a != 2'b00) begin
            check("a_rd_onehot", 32'($onehot(rd_en_a)), 32'd1);
            check("a_no_underflow", 32'(|(rd_en_a & empty_a)), 32'd0);
        end
        if (rd_en_b != 3'b000) begin
            check("b_rd_onehot", 32'($onehot(rd_en_b)), 32'd1);
            check("b_no_underflow", 32'(|(rd_en_b & empty_b)), 32'd0);
        end
    end

    initial begin
        // Reset state
        step(2);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_rd_en", 32'(rd_en_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_src", 32'(src_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_rd_en_b", 32'(rd_en_b), 32'd0);
        rst = 1'b0;
        step(1);

        // Single word 0xA5 from source 0: exact latency
        ready_a = 1'b1;
        push_a(0, 8'hA5, 1'b1);
        step();
        check("t1_rd_pulse", 32'(rd_en_a), 32'h1);
        check("t1_valid_early", 32'(valid_a), 32'd0);
        step();
        check("t1_rd_one_cycle", 32'(rd_en_a), 32'h0);
        check("t1_valid_latch", 32'(valid_a), 32'd0);
        step();
        check("t1_valid", 32'(valid_a), 32'd1);
        check("t1_data", 32'(data_a), 32'hA5);
        check("t1_src", 32'(src_a), 32'd0);
        step();
        check("t1_valid_drop", 32'(valid_a), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_rd_quiet", 32'(rd_en_a), 32'h0);
        end
        drain_a("t1_drain");

        // Burst fairness, both sources 6 words
        do_reset();
        for (int i = 0; i < 6; i++) begin
            mem_a[0][wp_a[0]] = 8'h10 + 8'(i); wp_a[0]++;
            mem_a[1][wp_a[1]] = 8'h20 + 8'(i); wp_a[1]++;
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(word_t'{src: 1'b0, data: 8'h10 + 8'(i)});
        for (int i = 0; i < 4; i++) exp_q.push_back(word_t'{src: 1'b1, data: 8'h20 + 8'(i)});
        exp_q.push_back(word_t'{src: 1'b0, data: 8'h14});
        exp_q.push_back(word_t'{src: 1'b0, data: 8'h15});
        exp_q.push_back(word_t'{src: 1'b1, data: 8'h24});
        exp_q.push_back(word_t'{src: 1'b1, data: 8'h25});
        drain_a("t2_drain");

        // Backpressure: hold 0x3C for 10 cycles
        do_reset();
        ready_a = 1'b0;
        push_a(1, 8'h3C, 1'b1);
        wait_valid_a("t3_wait_valid");
        push_a(0, 8'h44, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t3_hold_data", 32'(data_a), 32'h3C);
            check("t3_hold_valid", 32'(valid_a), 32'd1);
            check("t3_no_rd", 32'(rd_en_a), 32'h0);
        end
        ready_a = 1'b1;
        step();
        check("t3_valid_drop", 32'(valid_a), 32'd0);
        drain_a("t3_drain");

        // Single source 1, 9 words, 4-cycle spacing
        hs_cyc.delete();
        for (int i = 0; i < 9; i++) push_a(1, 8'h50 + 8'(i), 1'b1);
        drain_a("t4_drain");
        check("t4_count", 32'(hs_cyc.size()), 32'd9);
        for (int i = 1; i < hs_cyc.size(); i++) begin
            check("t4_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd4);
        end

        // Asynchronous reset mid-SEND
        do_reset();
        ready_a = 1'b0;
        push_a(1, 8'h77, 1'b0);
        wait_valid_a("t5_wait_valid");
        check("t5_data_pre", 32'(data_a), 32'h77);
        #2 rst = 1'b1;
        #1;
        check("t5_valid_rst", 32'(valid_a), 32'd0);
        check("t5_rd_rst", 32'(rd_en_a), 32'h0);
        check("t5_data_rst", 32'(data_a), 32'h0);
        check("t5_src_rst", 32'(src_a), 32'd0);
        check("t5_busy_rst", 32'(busy_a), 32'd0);
        step();
        rst = 1'b0;
        ready_a = 1'b1;
        push_a(0, 8'h81, 1'b1);
        push_a(1, 8'h91, 1'b1);
        drain_a("t5_drain");

        // NUM_SRC=3 wrap-around scan
        push_b(0, 8'hB0);
        wait_b(0, "t6_wait_rd0");
        check("t6_rd0", 32'(rd_en_b), 32'h1);
        wait_b(1, "t6_wait_v0");
        check("t6_data0", 32'(data_b), 32'hB0);
        check("t6_src0", 32'(src_b), 32'd0);
        step();
        wait_b(2, "t6_idle0");
        push_b(2, 8'hC2);
        wait_b(0, "t6_wait_rd2");
        check("t6_rd2", 32'(rd_en_b), 32'h4);
        wait_b(1, "t6_wait_v2");
        check("t6_data2", 32'(data_b), 32'hC2);
        check("t6_src2", 32'(src_b), 32'd2);
        step();
        wait_b(2, "t6_idle2");
        push_b(0, 8'hD0);
        wait_b(0, "t6_wait_rdw");
        check("t6_rd_wrap", 32'(rd_en_b), 32'h1);
        wait_b(1, "t6_wait_vw");
        check("t6_data_wrap", 32'(data_b), 32'hD0);
        check("t6_src_wrap", 32'(src_b), 32'd0);
        step(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Round-robin drain controller that shares one downstream ready/valid consumer (e.g. UART transmitter) between NUM_SRC upstream FIFOs.
- Drives each FIFO's rd_en, absorbs the FIFO's one-cycle registered-read latency, holds the word stable until accepted, and tags it with its source index.
- Enforces per-source burst fairness: at most BURST consecutive words from one source while another source is non-empty.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- NUM_SRC, 2, number of upstream FIFOs, 2..8.
- BURST, 4, max consecutive grants to one source while another is waiting, >=1.
- SRC_W, $clog2(NUM_SRC), source index width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- src_empty  in  NUM_SRC  per-source FIFO empty flag; bit i belongs to source i.
- src_dout  in  NUM_SRC*WIDTH  flattened FIFO read data; slice [i*WIDTH +: WIDTH] belongs to source i. Valid only in the cycle after that source's rd_en.
- src_rd_en  out  NUM_SRC  one-hot-or-zero read strobe to the FIFOs.
- out_valid  out  1  out_data/out_src hold a word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  WIDTH  word being offered.
- out_src  out  SRC_W  index of the source that produced out_data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, src_rd_en=0, out_valid=0, out_data=0, out_src=0, grant=0, burst_cnt=0. A reset mid-transfer drops any in-flight word; no rd_en is issued afterwards until a fresh IDLE decision.
- FSM states: IDLE, READ, LATCH, SEND.
- IDLE: if any src_empty bit is 0, select grant (see below) and go to READ; else stay.
- READ: src_rd_en[grant]=1 for exactly one cycle (decoded from state, registered grant); all other bits 0. Go to LATCH.
- LATCH: src_rd_en=0. Register out_data <= src_dout[grant slice], out_src <= grant. Go to SEND.
- SEND: out_valid=1. out_data and out_src are stable until the handshake. On out_valid && out_ready: out_valid falls next cycle, burst_cnt updates, go to IDLE.
- Latency: IDLE decision in cycle T, rd_en in T+1, capture at the end of T+2, out_valid from T+3. Minimum 4 cycles per word; the block never pipelines a second read.
- Arbitration in IDLE, with last = current grant:
  - If src_empty[last]=0 and burst_cnt < BURST-1, re-grant last.
  - Otherwise, grant the first non-empty source scanning last+1, last+2, ... (mod NUM_SRC), wrapping back to last.
- burst_cnt: on a handshake, burst_cnt <= (new grant == previous grant) ? burst_cnt+1 : 0. It saturates at BURST-1; the switch decision uses the count value.
- If only one source is non-empty, it is granted indefinitely; burst_cnt saturating does not stall it.
- The FIFO drives dout to 0 when not reading, so capture happens only in LATCH; src_dout is ignored in every other state.
- Empty is sampled only in IDLE. A source is never read while it is empty, so underflow is impossible.
- out_ready is ignored outside SEND. out_ready held high gives back-to-back words at 4-cycle spacing.

Decomposition:
- Shared package: FSM state encodings (IDLE=2'd0, READ=2'd1, LATCH=2'd2, SEND=2'd3) and a localparam for SRC_W.
- One natural sub-module: rr_pick. Combinational next-grant selector taking the empty vector, last grant, burst_cnt and BURST, and returning next_grant and any_req.
- The top level holds the FSM, registers and output mux.

Test Plan:
- Source 0 holds 0xA5, source 1 is empty, out_ready=1 -> src_rd_en=2'b01 for one cycle; out_valid at T+3 with out_data=0xA5, out_src=0; rd_en stays 0 afterwards.
- Both sources hold 6 words (0x10..0x15 and 0x20..0x25), BURST=4, out_ready=1 -> output order is 0x10..0x13, 0x20..0x23, 0x14, 0x15, 0x24, 0x25 with matching out_src.
- Backpressure: out_ready=0 for 10 cycles in SEND -> out_data=0x3C held constant, no further src_rd_en pulses; the word is accepted on the first out_ready=1 and out_valid drops the next cycle.
- Single source 1 holds 9 words, BURST=4 -> all 9 granted consecutively to source 1, with no idle gaps beyond the 4-cycle spacing.
- rst asserted asynchronously mid-SEND (out_valid=1, out_data=0x77) -> out_valid, src_rd_en and out_data go to 0 immediately; after release, the next IDLE re-arbitrates from grant=0.
- NUM_SRC=3, only source 2 non-empty after last grant 0 -> wrap-around scan selects source 2 and src_rd_en=3'b100.
